// File: rtl/instr_fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_stage_if
//  Purpose  : Instruction-memory request/response bus between the IF stage
//             (master) and the instruction memory (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface instr_fetch_stage_if #(
    parameter int PC_W    = 9,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    // Fetch stage: issues requests, consumes responses
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    // Instruction memory: consumes requests, returns responses
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_stage
//  Purpose  : IF stage of a 5-stage RISC-V pipeline. Owns the PC, issues
//             single-outstanding instruction fetches, absorbs variable memory
//             latency, feeds the IF/ID buffer, honours stall/redirect and
//             parks on the halt instruction.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch_stage #(
    parameter int                 PC_W       = 9,
    parameter int                 INSTR_W    = 32,
    parameter logic [INSTR_W-1:0] HALT_INSTR = 32'h0000_0073,
    parameter logic [INSTR_W-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               stall,
    input  wire logic               redirect,
    input  wire logic [PC_W-1:0]    redirect_pc,
    instr_fetch_stage_if.master     imem,
    output logic                    ifid_valid,
    output logic [PC_W-1:0]         ifid_pc,
    output logic [INSTR_W-1:0]      ifid_instr,
    output logic                    ifid_halt
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] c_PC_STEP    = PC_W'(4);
    localparam logic [PC_W-1:0] c_ALIGN_MASK = ~PC_W'(3);

    state_t               r_state;
    logic [PC_W-1:0]      r_pc;
    logic                 r_kill;
    logic [PC_W-1:0]      r_skid_pc;
    logic [INSTR_W-1:0]   r_skid_instr;
    logic                 r_imem_req;
    logic [PC_W-1:0]      r_imem_addr;
    logic                 r_ifid_valid;
    logic [PC_W-1:0]      r_ifid_pc;
    logic [INSTR_W-1:0]   r_ifid_instr;
    logic                 r_ifid_halt;

    state_t               w_state_next;
    logic [PC_W-1:0]      w_pc_next;
    logic                 w_kill_next;
    logic                 w_skid_we;
    logic                 w_ifid_we;
    logic                 w_ifid_clr;
    logic [PC_W-1:0]      w_load_pc;
    logic [INSTR_W-1:0]   w_load_instr;
    logic                 w_load_halt;
    logic                 w_req_next;

    // Source of an IF/ID load is either the live response or the skid entry
    assign w_load_halt = (w_load_instr == HALT_INSTR);

    // Next-state, PC, kill and IF/ID control; redirect overrides everything
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_kill_next  = r_kill;
        w_skid_we    = 1'b0;
        w_ifid_we    = 1'b0;
        w_ifid_clr   = 1'b0;
        w_load_pc    = r_pc;
        w_load_instr = imem.imem_rdata;

        case (r_state)
            S_REQ: begin
                // Pulse is on the bus this cycle; right after reset it is
                // not yet, so we stay here one cycle to launch it.
                if (r_imem_req) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    if (r_kill) begin
                        w_kill_next  = 1'b0;
                        w_state_next = S_REQ;
                    end else if (stall) begin
                        w_skid_we    = 1'b1;
                        w_state_next = S_HOLD;
                    end else begin
                        w_ifid_we    = 1'b1;
                        w_pc_next    = r_pc + c_PC_STEP;
                        w_state_next = w_load_halt ? S_HALT : S_REQ;
                    end
                end
            end
            S_HOLD: begin
                w_load_pc    = r_skid_pc;
                w_load_instr = r_skid_instr;
                if (!stall) begin
                    w_ifid_we    = 1'b1;
                    w_pc_next    = r_skid_pc + c_PC_STEP;
                    w_state_next = w_load_halt ? S_HALT : S_REQ;
                end
            end
            S_HALT: begin
                // Decode takes the halt on the first unstalled cycle
                if (!stall) begin
                    w_ifid_clr = 1'b1;
                end
            end
            default: begin
                w_state_next = S_REQ;
            end
        endcase

        if (redirect) begin
            w_pc_next  = redirect_pc & c_ALIGN_MASK;
            w_ifid_we  = 1'b0;
            w_skid_we  = 1'b0;
            w_ifid_clr = 1'b1;
            // A fetch in flight whose response has not arrived must be
            // swallowed later; a response arriving now is simply dropped.
            if ((r_state == S_WAIT && !imem.imem_rvalid) ||
                (r_state == S_REQ && r_imem_req)) begin
                w_kill_next  = 1'b1;
                w_state_next = S_WAIT;
            end else begin
                w_kill_next  = 1'b0;
                w_state_next = S_REQ;
            end
        end
    end

    // Entering S_REQ launches the registered request pulse at the new PC
    assign w_req_next = (w_state_next == S_REQ);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC, kill flag and skid buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= '0;
            r_kill       <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= NOP_INSTR;
        end else begin
            r_pc   <= w_pc_next;
            r_kill <= w_kill_next;
            if (w_skid_we) begin
                r_skid_pc    <= r_pc;
                r_skid_instr <= imem.imem_rdata;
            end
        end
    end

    // Registered instruction-memory request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_imem_req  <= 1'b0;
            r_imem_addr <= '0;
        end else begin
            r_imem_req <= w_req_next;
            if (w_req_next) begin
                r_imem_addr <= w_pc_next;
            end
        end
    end

    // IF/ID buffer: bubble on redirect/halt consumption, load when allowed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_halt  <= 1'b0;
        end else if (w_ifid_clr) begin
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_halt  <= 1'b0;
        end else if (w_ifid_we) begin
            r_ifid_valid <= 1'b1;
            r_ifid_pc    <= w_load_pc;
            r_ifid_instr <= w_load_instr;
            r_ifid_halt  <= w_load_halt;
        end
    end

    assign imem.imem_req  = r_imem_req;
    assign imem.imem_addr = r_imem_addr;
    assign ifid_valid     = r_ifid_valid;
    assign ifid_pc        = r_ifid_pc;
    assign ifid_instr     = r_ifid_instr;
    assign ifid_halt      = r_ifid_halt;

endmodule
`default_nettype wire

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
Instruction-fetch (IF) stage of the 5-stage RISC-V pipeline. It owns the PC and issues requests to the instruction memory. It accepts variable-latency responses and drives the IF/ID buffer fields (Curr_Pc, Curr_Instr, halt) plus a valid bit into the decode stage. It obeys stall from the hazard unit and redirect (flush) from the branch unit, and parks on a halt instruction.

Parameters:
PC_W, 9, PC width in bits; byte address, word aligned.
INSTR_W, 32, instruction width.
HALT_INSTR, 32'h0000_0073, encoding that marks program end.
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
stall  in  1  hazard unit: hold the IF/ID contents.
redirect  in  1  branch unit: flush and jump to redirect_pc.
redirect_pc  in  PC_W  branch/jump target.
imem_req  out  1  one-cycle fetch request pulse.
imem_addr  out  PC_W  fetch address; valid while imem_req=1.
imem_rvalid  in  1  response strobe; at most one per request, ≥1 cycle after the request.
imem_rdata  in  INSTR_W  instruction data; valid with imem_rvalid.
ifid_valid  out  1  IF/ID holds a real instruction.
ifid_pc  out  PC_W  Curr_Pc of the IF/ID instruction.
ifid_instr  out  INSTR_W  Curr_Instr.
ifid_halt  out  1  halt flag for the IF/ID instruction.

Behaviour:
- Reset (reset=0, async) sets: pc=0, state=S_REQ, kill=0, skid empty, imem_req=0, imem_addr=0, ifid_valid=0, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_halt=0. The first request issues in the first cycle after reset deasserts.
- All outputs are registered.
- States: S_REQ, S_WAIT, S_HOLD, S_HALT.
- S_REQ: imem_req=1 and imem_addr=pc for exactly one cycle, then -> S_WAIT. At most one request is outstanding.
- S_WAIT, imem_rvalid=1, kill=0:
  - stall=0: load IF/ID with {valid=1, pc, imem_rdata, halt=(imem_rdata==HALT_INSTR)}. Set pc <= pc+4 (mod 2^PC_W, wraps 508->0). Next state is S_HALT if the instruction is a halt, else S_REQ.
  - stall=1: capture pc and data into the skid register and go to S_HOLD. IF/ID is unchanged.
- S_WAIT, imem_rvalid=1, kill=1: discard the response, clear kill, go to S_REQ. pc already holds the redirect target.
- S_HOLD: when stall=0, move the skid into IF/ID (same rules as above) and go to S_REQ or S_HALT. No request issues while in S_HOLD.
- stall=1 in any state: IF/ID is held bit-exact. A request already issued completes normally.
- S_HALT: no requests. IF/ID keeps the halt instruction until stall=0 lets decode consume it; afterwards IF/ID goes to bubble (valid=0, NOP, halt=0). The block stays in S_HALT until redirect.
- Redirect has the highest priority over stall, response and halt, in any state:
  - pc <= {redirect_pc[PC_W-1:2], 2'b00}.
  - IF/ID <= bubble (valid=0, instr=NOP_INSTR, halt=0, pc=0). Skid is dropped.
  - If a request is outstanding (S_WAIT with no rvalid this cycle): kill<=1 and stay in S_WAIT. Else: go to S_REQ.
  - Redirect plus rvalid in the same cycle: the response is discarded, no kill is set, next state is S_REQ.
  - Redirect in S_REQ: the pulse still goes out at the old address and the block enters S_WAIT with kill=1.
- Consecutive redirects: the last one wins. kill stays a single bit because at most one request is outstanding.
- Reset asserted mid-transaction: any late imem_rvalid before the first post-reset request is ignored (state S_REQ ignores rvalid).
- Throughput: one instruction per 2 cycles with zero-wait memory. A memory latency of L cycles gives 1 per (L+1).

Test Plan:
- Reset, then zero-wait memory returning addi words -> imem_req pulses at addrs 0,4,8. IF/ID loads pc 0,4,8 on alternate cycles with ifid_valid=1.
- Raise stall for 3 cycles while a response for pc=8 arrives -> IF/ID holds pc=4 unchanged, the skid captures pc 8, and no new imem_req. When stall drops, IF/ID shows pc=8 in the next cycle.
- Redirect to 0x40 while the response for pc=12 is outstanding (latency 3) -> that response is discarded, IF/ID is a bubble (NOP, valid=0), and the next imem_addr is 0x40.
- Redirect to 0x43 together with imem_rvalid -> the response is dropped and the next imem_addr is 0x40.
- Fetch HALT_INSTR at pc=0x20 -> ifid_halt=1, and no further imem_req for 20 cycles. Redirect to 0 then resumes fetching at 0.
- pc=508 fetch -> the next imem_addr is 0 (wrap). Assert reset mid-S_WAIT with a late rvalid -> outputs return to reset values, the late response is ignored, and fetch restarts at 0.
